// File: rtl/clk_div_bank.sv
// Bank of runtime-programmable clock dividers: each channel emits a one-cycle tick
// every D cycles and a 50%-duty square wave of period 2*D, with shadowed divisor reload.
module clk_div_bank #(
    parameter int CHANNELS    = 4,
    parameter int WIDTH       = 20,
    parameter int DEFAULT_DIV = 416666,
    localparam int SEL_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk_in,
    input  logic                reset,
    input  logic [CHANNELS-1:0] en,
    input  logic                sync_restart,
    input  logic                div_wr,
    input  logic [SEL_W-1:0]    div_sel,
    input  logic [WIDTH-1:0]    div_data,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] upd_done
);

    // div_wr is a single-cycle strobe with no backpressure: a write is accepted on
    // every edge where it is high and div_sel names an existing channel.
    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        logic [WIDTH-1:0] r_cnt;
        logic [WIDTH-1:0] r_div;
        logic [WIDTH-1:0] r_shadow;
        logic             r_pending;
        logic             r_tick;
        logic             r_clk;
        logic             r_upd;

        logic w_wr_hit;
        logic w_run;
        logic w_last;
        logic w_apply;

        assign w_wr_hit = div_wr && (div_sel == SEL_W'(g));
        assign w_run    = en[g] && (r_div != '0);
        // >= keeps a channel from running away when a smaller divisor lands
        // while the held count already exceeds it.
        assign w_last   = w_run && (r_cnt >= r_div - WIDTH'(1));
        assign w_apply  = r_pending &&
                          (sync_restart || w_last || !en[g] || (r_div == '0));

        always_ff @(posedge clk_in) begin
            if (reset) begin
                r_cnt     <= '0;
                r_div     <= WIDTH'(DEFAULT_DIV);
                r_shadow  <= WIDTH'(DEFAULT_DIV);
                r_pending <= 1'b0;
                r_tick    <= 1'b0;
                r_clk     <= 1'b0;
                r_upd     <= 1'b0;
            end else begin
                r_upd <= w_apply;
                if (w_apply) begin
                    r_div <= r_shadow;
                end
                // A write on an apply edge lands after the old shadow was consumed.
                if (w_wr_hit) begin
                    r_shadow  <= div_data;
                    r_pending <= 1'b1;
                end else if (w_apply) begin
                    r_pending <= 1'b0;
                end

                if (sync_restart) begin
                    r_cnt  <= '0;
                    r_clk  <= 1'b0;
                    r_tick <= 1'b0;
                end else if (w_last) begin
                    r_cnt  <= '0;
                    r_tick <= 1'b1;
                    r_clk  <= ~r_clk;
                end else if (w_run) begin
                    r_cnt  <= r_cnt + WIDTH'(1);
                    r_tick <= 1'b0;
                end else begin
                    r_tick <= 1'b0;
                    if (r_div == '0) begin
                        r_cnt <= '0;
                    end
                end
            end
        end

        assign tick[g]     = r_tick;
        assign clk_out[g]  = r_clk;
        assign upd_done[g] = r_upd;
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank (3 channels, 8-bit divisors, reset divisor 5);
// expected outputs are hand-derived per edge index k after reset release.
module tb_clk_div_bank;

    localparam int CH = 3;
    localparam int W  = 8;

    logic          clk_in = 1'b0;
    logic          reset;
    logic [CH-1:0] en;
    logic          sync_restart;
    logic          div_wr;
    logic [1:0]    div_sel;
    logic [W-1:0]  div_data;
    logic [CH-1:0] tick;
    logic [CH-1:0] clk_out;
    logic [CH-1:0] upd_done;

    int n_vec = 0;
    int n_err = 0;

    clk_div_bank #(
        .CHANNELS   (CH),
        .WIDTH      (W),
        .DEFAULT_DIV(5)
    ) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .en          (en),
        .sync_restart(sync_restart),
        .div_wr      (div_wr),
        .div_sel     (div_sel),
        .div_data    (div_data),
        .tick        (tick),
        .clk_out     (clk_out),
        .upd_done    (upd_done)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        en           = 3'b111;
        sync_restart = 1'b0;
        div_wr       = 1'b0;
        div_sel      = 2'd0;
        div_data     = '0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [2:0] exp_t, exp_c;
        do_reset();
        n_vec++;
        if (tick !== 3'b000) begin n_err++; $display("FAIL reset_tick got=%b exp=000", tick); end
        n_vec++;
        if (clk_out !== 3'b000) begin n_err++; $display("FAIL reset_clk got=%b exp=000", clk_out); end
        n_vec++;
        if (upd_done !== 3'b000) begin n_err++; $display("FAIL reset_upd got=%b exp=000", upd_done); end
        for (int k = 1; k <= 20; k++) begin
            step();
            exp_t = (k % 5 == 0) ? 3'b111 : 3'b000;
            exp_c = ((k / 5) % 2 == 1) ? 3'b111 : 3'b000;
            n_vec++;
            if (tick !== exp_t) begin n_err++; $display("FAIL default_tick k=%0d got=%b exp=%b", k, tick, exp_t); end
            n_vec++;
            if (clk_out !== exp_c) begin n_err++; $display("FAIL default_clk k=%0d got=%b exp=%b", k, clk_out, exp_c); end
        end
    endtask

    task automatic test_write_midcount();
        logic [2:0] exp_t, exp_u;
        do_reset();
        for (int k = 1; k <= 15; k++) begin
            div_wr   = (k == 3) || (k == 4);
            div_sel  = 2'd1;
            div_data = (k == 3) ? 8'd7 : 8'd3;
            step();
            exp_t = {k % 5 == 0, (k == 5) || (k > 5 && (k - 5) % 3 == 0), k % 5 == 0};
            exp_u = (k == 5) ? 3'b010 : 3'b000;
            n_vec++;
            if (tick !== exp_t) begin n_err++; $display("FAIL write_tick k=%0d got=%b exp=%b", k, tick, exp_t); end
            n_vec++;
            if (upd_done !== exp_u) begin n_err++; $display("FAIL write_upd k=%0d got=%b exp=%b", k, upd_done, exp_u); end
        end
        div_wr = 1'b0;
    endtask

    task automatic test_div1_div0();
        logic       exp_t2, exp_c2;
        logic [2:0] exp_u;
        do_reset();
        for (int k = 1; k <= 16; k++) begin
            div_wr   = (k == 1) || (k == 10);
            div_sel  = 2'd2;
            div_data = (k == 1) ? 8'd1 : 8'd0;
            step();
            exp_t2 = (k == 5) || (k >= 6 && k <= 11);
            exp_c2 = (k < 5) ? 1'b0 : (k <= 11) ? (k % 2 == 1) : 1'b1;
            exp_u  = (k == 5 || k == 11) ? 3'b100 : 3'b000;
            n_vec++;
            if (tick[2] !== exp_t2) begin n_err++; $display("FAIL d1d0_tick k=%0d got=%b exp=%b", k, tick[2], exp_t2); end
            n_vec++;
            if (clk_out[2] !== exp_c2) begin n_err++; $display("FAIL d1d0_clk k=%0d got=%b exp=%b", k, clk_out[2], exp_c2); end
            n_vec++;
            if (upd_done !== exp_u) begin n_err++; $display("FAIL d1d0_upd k=%0d got=%b exp=%b", k, upd_done, exp_u); end
            n_vec++;
            if (tick[0] !== (k % 5 == 0)) begin n_err++; $display("FAIL d1d0_ch0 k=%0d got=%b exp=%b", k, tick[0], k % 5 == 0); end
        end
        div_wr = 1'b0;
    endtask

    task automatic test_sync_restart();
        logic [2:0] exp_t, exp_c, exp_u;
        do_reset();
        for (int k = 1; k <= 26; k++) begin
            div_wr       = (k == 1) || (k == 5) || (k == 11) || (k == 13);
            div_sel      = (k == 1) ? 2'd0 : (k == 5) ? 2'd1 : 2'd2;
            div_data     = (k == 1) ? 8'd4 : (k == 5) ? 8'd6 : (k == 11) ? 8'd7 : 8'd3;
            sync_restart = (k == 13);
            step();
            if (k < 13) begin
                exp_t = {(k == 5) || (k == 10), (k == 5) || (k == 10), (k == 5) || (k == 9)};
            end else begin
                exp_t = {k == 20 || k == 23 || k == 26,
                         k > 13 && (k - 13) % 6 == 0,
                         k > 13 && (k - 13) % 4 == 0};
                exp_c = {(k >= 20 && k <= 22) || k == 26,
                         ((k - 13) / 6) % 2 == 1,
                         ((k - 13) / 4) % 2 == 1};
                n_vec++;
                if (clk_out !== exp_c) begin n_err++; $display("FAIL sync_clk k=%0d got=%b exp=%b", k, clk_out, exp_c); end
            end
            exp_u = (k == 5) ? 3'b001 : (k == 10) ? 3'b010 :
                    (k == 13 || k == 20) ? 3'b100 : 3'b000;
            n_vec++;
            if (tick !== exp_t) begin n_err++; $display("FAIL sync_tick k=%0d got=%b exp=%b", k, tick, exp_t); end
            n_vec++;
            if (upd_done !== exp_u) begin n_err++; $display("FAIL sync_upd k=%0d got=%b exp=%b", k, upd_done, exp_u); end
        end
        div_wr       = 1'b0;
        sync_restart = 1'b0;
    endtask

    task automatic test_enable();
        logic [2:0] exp_t, exp_u;
        logic       exp_c0;
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            en       = (k >= 3 && k <= 9) ? 3'b110 : 3'b111;
            div_wr   = (k == 1);
            div_sel  = 2'd0;
            div_data = 8'd4;
            step();
            exp_t  = {k % 5 == 0, k % 5 == 0, k == 11 || k == 15 || k == 19};
            exp_u  = (k == 3) ? 3'b001 : 3'b000;
            exp_c0 = (k >= 11) ? (((k - 11) / 4) % 2 == 0) : 1'b0;
            n_vec++;
            if (tick !== exp_t) begin n_err++; $display("FAIL enable_tick k=%0d got=%b exp=%b", k, tick, exp_t); end
            n_vec++;
            if (upd_done !== exp_u) begin n_err++; $display("FAIL enable_upd k=%0d got=%b exp=%b", k, upd_done, exp_u); end
            n_vec++;
            if (clk_out[0] !== exp_c0) begin n_err++; $display("FAIL enable_clk k=%0d got=%b exp=%b", k, clk_out[0], exp_c0); end
        end
        en     = 3'b111;
        div_wr = 1'b0;
    endtask

    task automatic test_oob_and_reset();
        logic [2:0] exp_t, exp_c;
        do_reset();
        for (int k = 1; k <= 7; k++) begin
            div_wr   = (k == 1) || (k == 6);
            div_sel  = (k == 1) ? 2'd3 : 2'd0;
            div_data = 8'd2;
            step();
            exp_t = (k % 5 == 0) ? 3'b111 : 3'b000;
            n_vec++;
            if (tick !== exp_t) begin n_err++; $display("FAIL oob_tick k=%0d got=%b exp=%b", k, tick, exp_t); end
            n_vec++;
            if (upd_done !== 3'b000) begin n_err++; $display("FAIL oob_upd k=%0d got=%b exp=000", k, upd_done); end
        end
        div_wr = 1'b0;
        reset  = 1'b1;
        step();
        reset = 1'b0;
        n_vec++;
        if ({tick, clk_out, upd_done} !== 9'b0) begin
            n_err++;
            $display("FAIL midreset_outputs got=%b exp=000000000", {tick, clk_out, upd_done});
        end
        for (int k = 1; k <= 10; k++) begin
            step();
            exp_t = (k % 5 == 0) ? 3'b111 : 3'b000;
            exp_c = ((k / 5) % 2 == 1) ? 3'b111 : 3'b000;
            n_vec++;
            if (tick !== exp_t) begin n_err++; $display("FAIL postreset_tick k=%0d got=%b exp=%b", k, tick, exp_t); end
            n_vec++;
            if (clk_out !== exp_c) begin n_err++; $display("FAIL postreset_clk k=%0d got=%b exp=%b", k, clk_out, exp_c); end
            n_vec++;
            if (upd_done !== 3'b000) begin n_err++; $display("FAIL postreset_upd k=%0d got=%b exp=000", k, upd_done); end
        end
    endtask

    initial begin
        test_reset();
        test_write_midcount();
        test_div1_div0();
        test_sync_restart();
        test_enable();
        test_oob_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
